if_fetch_stage: RTL

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_fetch_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues one instruction-memory request at a time, loads the
// IF/ID register, holds a response while ID is stalled and drains a discarded response
// after a redirect.
// Optional performance counters are built only when IF_PERF_CNT_EN is defined.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_flag,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_IR,
  output logic [31:0] if_id_PC,
  output logic        if_id_valid_inst,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic [31:0] ir_q;
  logic [31:0] id_pc_q;
  logic        valid_q;

  logic        deliver;
  logic [31:0] deliver_word;

  // A delivery happens from a fresh response or from the holding buffer, never under redirect.
  always_comb begin
    deliver      = 1'b0;
    deliver_word = imem_data;
    if (!take_branch && !id_stall_flag) begin
      if (state_q == StWait && imem_valid) begin
        deliver = 1'b1;
      end else if (state_q == StHold) begin
        deliver      = 1'b1;
        deliver_word = buf_q;
      end
    end
  end

  // Fetch FSM together with PC, holding buffer and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      ir_q    <= NOP_INST;
      id_pc_q <= '0;
      valid_q <= 1'b0;
    end else if (take_branch) begin
      pc_q    <= branch_target;
      buf_q   <= '0;
      ir_q    <= NOP_INST;
      valid_q <= 1'b0;
      // An in-flight request must still be drained so its response is not mistaken later.
      unique case (state_q)
        StReq:   state_q <= StDrain;
        StWait:  state_q <= imem_valid ? StReq : StDrain;
        StHold:  state_q <= StReq;
        StDrain: state_q <= imem_valid ? StReq : StDrain;
        default: state_q <= StReq;
      endcase
    end else begin
      if (deliver) begin
        ir_q    <= deliver_word;
        id_pc_q <= pc_q;
        valid_q <= 1'b1;
        pc_q    <= pc_q + 32'd4;
      end
      unique case (state_q)
        StReq: state_q <= StWait;
        StWait: begin
          if (imem_valid) begin
            if (id_stall_flag) begin
              buf_q   <= imem_data;
              state_q <= StHold;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StHold:  if (!id_stall_flag) state_q <= StReq;
        StDrain: if (imem_valid) state_q <= StReq;
        default: state_q <= StReq;
      endcase
    end
  end

  // Request strobe is gated by reset so nothing is issued during the reset cycle.
  assign imem_req         = (state_q == StReq) && !rst;
  assign imem_addr        = pc_q;
  assign if_id_IR         = ir_q;
  assign if_id_PC         = id_pc_q;
  assign if_id_valid_inst = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  // Delivered-instruction and stalled-cycle counters, both free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (deliver) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (id_stall_flag && !take_branch) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule
